// File: rtl/snap_phase_addr_ctrl.sv
// snap_phase_addr_ctrl
// Capture controller for the snapPhase BRAM. It waits for a software arm edge
// and then a valid trigger sample. From that sample it writes 2^ADDR_WIDTH
// consecutive valid samples into the BRAM. It also publishes a live status word
// (done / busy / armed / sample count), which the PPC polls through the
// snapPhase_addr register. Everything runs on user_clk.
module snap_phase_addr_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  arm,
    input  logic                  trig,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic [31:0]           addr_out,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Count value at which the sample being written lands in the last address.
    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   next_count;
    logic                  arm_d;
    logic                  arm_rise;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           status;

    assign arm_rise = arm & ~arm_d;

    // State, sample count and the arm edge-detect history.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state <= IDLE;
            count <= '0;
            arm_d <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            arm_d <= arm;
        end
    end

    // Next-state logic and write qualification. Once CAPTURE starts it always
    // runs to completion, because arm and trig are ignored there.
    always_comb begin
        next_state = state;
        next_count = count;
        wr_en      = 1'b0;
        wr_addr    = count[ADDR_WIDTH-1:0];
        case (state)
            IDLE: begin
                if (arm_rise) begin
                    next_count = '0;
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (trig && din_valid) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    next_count = ONE;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (din_valid) begin
                    wr_en      = 1'b1;
                    next_count = count + ONE;
                    if (count == LAST_IDX) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (arm_rise) begin
                    next_count = '0;
                    next_state = ARMED;
                end
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
            end
        endcase
    end

    // The status word is built from next-state values so that it changes on
    // the same edge that presents the matching BRAM write.
    always_comb begin
        status               = '0;
        status[31]           = (next_state == DONE);
        status[30]           = (next_state == ARMED) || (next_state == CAPTURE);
        status[29]           = (next_state == ARMED);
        status[ADDR_WIDTH:0] = next_count;
    end

    // Registered BRAM write port, status word and done flag.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            addr_out  <= '0;
            done      <= 1'b0;
        end else begin
            bram_we  <= wr_en;
            addr_out <= status;
            done     <= (next_state == DONE);
            if (wr_en) begin
                bram_addr <= wr_addr;
                bram_din  <= din;
            end
        end
    end

endmodule

// File: tb/tb_snap_phase_addr_ctrl.sv
// Directed testbench for snap_phase_addr_ctrl with a 16-deep capture.
module tb_snap_phase_addr_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          user_clk;
    logic          user_rst;
    logic          arm;
    logic          trig;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [31:0]   addr_out;
    logic          done;

    int n_checks;
    int n_fails;
    int cyc;
    int wr_cnt;
    int base;
    logic [31:0] log_addr [512];
    logic [31:0] log_data [512];
    int          log_cyc  [512];

    snap_phase_addr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .arm       (arm),
        .trig      (trig),
        .din_valid (din_valid),
        .din       (din),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .addr_out  (addr_out),
        .done      (done)
    );

    // 10 ns clock.
    initial begin
        user_clk = 1'b0;
        forever #5 user_clk = ~user_clk;
    end

    // Free-running cycle counter used to measure write spacing.
    always @(posedge user_clk) begin
        cyc <= cyc + 1;
    end

    // Log every BRAM write, sampled on the falling edge.
    always @(negedge user_clk) begin
        if (bram_we === 1'b1 && wr_cnt < 512) begin
            log_addr[wr_cnt] = 32'(bram_addr);
            log_data[wr_cnt] = bram_din;
            log_cyc[wr_cnt]  = cyc;
            wr_cnt           = wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic t, input logic v, input logic [DW-1:0] d);
        arm       = a;
        trig      = t;
        din_valid = v;
        din       = d;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkLog(input string tag, input int b, input int n, input logic [31:0] dbase, input int gap);
        checkOutput({tag, "_nwrites"}, 32'(wr_cnt - b), 32'(n));
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_addr%0d", tag, k), log_addr[b+k], 32'(k));
            checkOutput($sformatf("%s_data%0d", tag, k), log_data[b+k], dbase + 32'(k));
            if (k > 0) begin
                checkOutput($sformatf("%s_gap%0d", tag, k), 32'(log_cyc[b+k] - log_cyc[b+k-1]), 32'(gap));
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        cyc       = 0;
        wr_cnt    = 0;
        user_rst  = 1'b1;
        arm       = 1'b0;
        trig      = 1'b0;
        din_valid = 1'b0;
        din       = '0;

        // Reset values.
        #12;
        checkOutput("rst_we", 32'(bram_we), 32'd0);
        checkOutput("rst_addr_out", addr_out, 32'h0);
        checkOutput("rst_done", 32'(done), 32'd0);
        user_rst = 1'b0;
        tick();

        // Idle with arm low: trigger and valid activity must not cause writes.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, i[0], i[1], 32'h0DEAD000 + 32'(i));
        end
        checkOutput("idle_nwrites", 32'(wr_cnt), 32'd0);
        checkOutput("idle_addr_out", addr_out, 32'h0);

        // Arm, test an unqualified trigger, then capture with continuous valid.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("armed_addr_out", addr_out, 32'h6000_0000);
        checkOutput("armed_done", 32'(done), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h55);
        checkOutput("trig_novalid_we", 32'(bram_we), 32'd0);
        checkOutput("trig_novalid_addr_out", addr_out, 32'h6000_0000);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        base = wr_cnt;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, (i == 0), 1'b1, 32'h100 + 32'(i));
            if (i == 0) begin
                checkOutput("first_we", 32'(bram_we), 32'd1);
                checkOutput("first_addr", 32'(bram_addr), 32'd0);
            end
            if (i == 4) begin
                checkOutput("mid_addr_out", addr_out, 32'h4000_0005);
            end
        end
        checkOutput("last_we", 32'(bram_we), 32'd1);
        checkOutput("last_addr", 32'(bram_addr), 32'd15);
        checkOutput("last_din", bram_din, 32'h10F);
        checkOutput("last_addr_out", addr_out, 32'h8000_0010);
        checkOutput("last_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("after_we", 32'(bram_we), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h999);
        checkOutput("done_nowrite_we", 32'(bram_we), 32'd0);
        checkOutput("done_hold_addr_out", addr_out, 32'h8000_0010);
        checkLog("cont", base, 16, 32'h100, 1);

        // Re-arm from DONE, then capture with valid on alternate cycles,
        // toggling arm mid-capture and asserting trig again.
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("rearm_addr_out", addr_out, 32'h6000_0000);
        checkOutput("rearm_done", 32'(done), 32'd0);
        base = wr_cnt;
        for (int j = 0; j < 32; j++) begin
            applyStimulus(!(j == 12 || j == 13), (j == 0 || j == 20), (j % 2 == 0), 32'h200 + 32'(j / 2));
            if (j == 16) begin
                checkOutput("gap_mid_addr_out", addr_out, 32'h4000_0009);
            end
        end
        checkOutput("gap_addr_out", addr_out, 32'h8000_0010);
        checkOutput("gap_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkLog("gap", base, 16, 32'h200, 2);

        // Asynchronous reset in the middle of a capture.
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        base = wr_cnt;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, (i == 0), 1'b1, 32'h300 + 32'(i));
        end
        checkOutput("pre_rst_we", 32'(bram_we), 32'd1);
        #2;
        user_rst = 1'b1;
        #1;
        checkOutput("async_rst_we", 32'(bram_we), 32'd0);
        checkOutput("async_rst_addr_out", addr_out, 32'h0);
        checkOutput("async_rst_done", 32'(done), 32'd0);
        checkOutput("async_rst_din", bram_din, 32'h0);
        #1;
        user_rst  = 1'b0;
        arm       = 1'b0;
        trig      = 1'b0;
        din_valid = 1'b0;
        tick();
        tick();
        checkOutput("post_rst_addr_out", addr_out, 32'h0);
        checkOutput("post_rst_nwrites", 32'(wr_cnt - base), 32'd8);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("post_rst_armed", addr_out, 32'h6000_0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h400);
        checkOutput("post_rst_we", 32'(bram_we), 32'd1);
        checkOutput("post_rst_addr", 32'(bram_addr), 32'd0);
        checkOutput("post_rst_din", bram_din, 32'h400);
        checkOutput("post_rst_status", addr_out, 32'h4000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
